// File: rtl/pipe_field_gen.sv
// Scrolling pipe field for the flappy-fish game: pipe positions, LFSR gap heights,
// per-pixel pipe render, fish/pipe collision, pass pulse and saturating BCD score.
module pipe_field_gen #(
   parameter int NUM_PIPES = 5,
   parameter int PIPE_W    = 32,
   parameter int SPACING   = 160,
   parameter int START_X   = 320,
   parameter int GAP_H     = 64,
   parameter int GAP_MIN   = 40,
   parameter int SPEED     = 1,
   parameter int FISH_SIZE = 20
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       run,
   input  logic       clear,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic [9:0] fish_x,
   input  logic [9:0] fish_y,
   output logic       pipe_px,
   output logic       hit,
   output logic       pass,
   output logic [7:0] score_bcd
);

   localparam logic [10:0] L_PIPE_W  = 11'(PIPE_W);
   localparam logic [10:0] L_GAP_H   = 11'(GAP_H);
   localparam logic [10:0] L_SPEED   = 11'(SPEED);
   localparam logic [10:0] L_FISH    = 11'(FISH_SIZE);
   localparam logic [10:0] L_WRAP    = 11'(NUM_PIPES * SPACING - SPEED);
   localparam logic [8:0]  L_GAP_MIN = 9'(GAP_MIN);

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] res;
      if (v == 8'h99) begin
         res = v;
      end else if (v[3:0] == 4'd9) begin
         res = {v[7:4] + 4'd1, 4'd0};
      end else begin
         res = {v[7:4], v[3:0] + 4'd1};
      end
      return res;
   endfunction

   logic [9:0]  r_x [NUM_PIPES];
   logic [8:0]  r_gap [NUM_PIPES];
   logic [15:0] r_lfsr;
   logic        r_pass;
   logic [7:0]  r_score;
   logic        r_pipe_px;
   logic        r_hit;

   logic [10:0] w_xe [NUM_PIPES];
   logic [10:0] w_ge [NUM_PIPES];
   logic [9:0]  w_x_nxt [NUM_PIPES];
   logic [8:0]  w_gap_nxt [NUM_PIPES];
   logic [NUM_PIPES-1:0] w_wrap_v;
   logic [NUM_PIPES-1:0] w_px_v;
   logic [NUM_PIPES-1:0] w_hit_v;
   logic [NUM_PIPES-1:0] w_pass_v;
   logic [10:0] w_pxe, w_pye, w_fxe, w_fye;
   logic        w_step;

   assign w_step = tick & run & ~clear;
   assign w_pxe  = {1'b0, pixel_x};
   assign w_pye  = {1'b0, pixel_y};
   assign w_fxe  = {1'b0, fish_x};
   assign w_fye  = {1'b0, fish_y};

   // All per-pipe geometry is carried in 11 bits so x+PIPE_W and the wrap sum never overflow.
   for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
      assign w_xe[g]     = {1'b0, r_x[g]};
      assign w_ge[g]     = {2'b00, r_gap[g]};
      assign w_wrap_v[g] = (w_xe[g] < L_SPEED);
      assign w_px_v[g]   = (w_pxe >= w_xe[g]) && (w_pxe < w_xe[g] + L_PIPE_W) &&
                           ((w_pye < w_ge[g]) || (w_pye >= w_ge[g] + L_GAP_H));
      assign w_hit_v[g]  = (w_fxe < w_xe[g] + L_PIPE_W) && (w_fxe + L_FISH >= w_xe[g]) &&
                           ((w_fye < w_ge[g]) || (w_fye + L_FISH >= w_ge[g] + L_GAP_H));
      assign w_pass_v[g] = w_step && !w_wrap_v[g] &&
                           (w_xe[g] + L_PIPE_W > w_fxe) &&
                           (w_xe[g] - L_SPEED + L_PIPE_W <= w_fxe);
   end

   // Next position and gap for each pipe on a physics step.
   always_comb begin
      for (int i = 0; i < NUM_PIPES; i++) begin
         w_x_nxt[i]   = r_x[i];
         w_gap_nxt[i] = r_gap[i];
         if (w_step) begin
            if (w_wrap_v[i]) begin
               w_x_nxt[i]   = 10'(w_xe[i] + L_WRAP);
               w_gap_nxt[i] = L_GAP_MIN + {1'b0, r_lfsr[7:0]};
            end else begin
               w_x_nxt[i]   = 10'(w_xe[i] - L_SPEED);
            end
         end else begin
            w_x_nxt[i]   = r_x[i];
            w_gap_nxt[i] = r_gap[i];
         end
      end
   end

   // Field state, LFSR and registered outputs; clear outranks tick and pass.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            r_x[i]   <= 10'(START_X + i * SPACING);
            r_gap[i] <= 9'(GAP_MIN + 32 * i);
         end
         r_lfsr    <= 16'hACE1;
         r_pass    <= 1'b0;
         r_score   <= 8'h00;
         r_pipe_px <= 1'b0;
         r_hit     <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            r_x[i]   <= 10'(START_X + i * SPACING);
            r_gap[i] <= 9'(GAP_MIN + 32 * i);
         end
         r_lfsr    <= 16'hACE1;
         r_pass    <= 1'b0;
         r_score   <= 8'h00;
         r_pipe_px <= 1'b0;
         r_hit     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            r_x[i]   <= w_x_nxt[i];
            r_gap[i] <= w_gap_nxt[i];
         end
         r_lfsr    <= lfsr_next(r_lfsr);
         r_pass    <= |w_pass_v;
         r_score   <= r_pass ? bcd_inc(r_score) : r_score;
         r_pipe_px <= |w_px_v;
         r_hit     <= |w_hit_v;
      end
   end

   assign pipe_px   = r_pipe_px;
   assign hit       = r_hit;
   assign pass      = r_pass;
   assign score_bcd = r_score;

endmodule

// File: tb/tb_pipe_field_gen.sv
// Self-checking bench for pipe_field_gen: pipe positions tracked by a small model,
// pass pulses checked through an expected-value queue, score against a pass counter.
module tb_pipe_field_gen;

   logic       clk = 1'b0;
   logic       reset_n, tick, run, clear;
   logic [9:0] pixel_x, pixel_y, fish_x, fish_y;
   logic       pipe_px, hit, pass;
   logic [7:0] score_bcd;

   int n_checks = 0;
   int n_fail   = 0;
   int mx [5];
   bit sb_q [$];
   int exp_cnt      = 0;
   int dut_pass_cnt = 0;

   pipe_field_gen dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .run(run), .clear(clear),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .fish_x(fish_x), .fish_y(fish_y),
      .pipe_px(pipe_px), .hit(hit), .pass(pass), .score_bcd(score_bcd)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < 5; i++) mx[i] = 320 + 160 * i;
   endfunction

   function automatic bit model_col(input int px);
      for (int i = 0; i < 5; i++) if (px >= mx[i] && px < mx[i] + 32) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [7:0] exp_bcd(input int c);
      int s;
      s = (c > 99) ? 99 : c;
      return 8'((s / 10) * 16 + (s % 10));
   endfunction

   task automatic probe(input int px, input int py, input bit exp, input string name);
      pixel_x = 10'(px);
      pixel_y = 10'(py);
      @(posedge clk); #1;
      n_checks++;
      if (pipe_px !== exp) begin
         n_fail++;
         $display("FAIL %s: pipe_px=%0b expected %0b at (%0d,%0d)", name, pipe_px, exp, px, py);
      end
   endtask

   task automatic check_positions(input string name);
      for (int i = 0; i < 5; i++) begin
         probe(mx[i], 0, model_col(mx[i]), name);
         probe(mx[i] + 32, 0, model_col(mx[i] + 32), name);
         if (mx[i] > 0) probe(mx[i] - 1, 0, model_col(mx[i] - 1), name);
      end
   endtask

   task automatic probe_hit(input int fx, input int fy, input bit exp, input string name);
      fish_x = 10'(fx);
      fish_y = 10'(fy);
      @(posedge clk); #1;
      n_checks++;
      if (hit !== exp) begin
         n_fail++;
         $display("FAIL %s: hit=%0b expected %0b fish (%0d,%0d)", name, hit, exp, fx, fy);
      end
   endtask

   // Each tick: step the model, queue the expected pass, then compare after the edge.
   task automatic run_ticks(input int n);
      bit pb, exp;
      for (int k = 0; k < n; k++) begin
         tick = 1'b1;
         pb = 1'b0;
         if (run && !clear) begin
            for (int i = 0; i < 5; i++) begin
               if (mx[i] == 0) mx[i] = 799;
               else begin
                  if (mx[i] + 31 == int'(fish_x)) pb = 1'b1;
                  mx[i] = mx[i] - 1;
               end
            end
         end
         sb_q.push_back(pb);
         @(posedge clk); #1;
         exp = 1'b0;
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL pass_queue: queue empty at tick %0d", k);
         end else begin
            exp = sb_q.pop_front();
            if (pass !== exp) begin
               n_fail++;
               $display("FAIL pass: got %0b expected %0b at tick %0d", pass, exp, k);
            end
         end
         if (pass === 1'b1) dut_pass_cnt++;
         n_checks++;
         if (score_bcd !== exp_bcd(exp_cnt)) begin
            n_fail++;
            $display("FAIL score: got %h expected %h at tick %0d", score_bcd, exp_bcd(exp_cnt), k);
         end
         if (exp) exp_cnt++;
      end
      tick = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; tick = 1'b0; run = 1'b0; clear = 1'b0;
      pixel_x = 10'd0; pixel_y = 10'd0; fish_x = 10'd0; fish_y = 10'd0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({pipe_px, hit, pass, score_bcd} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_hold: outputs %b expected 0", {pipe_px, hit, pass, score_bcd});
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
      model_reset();
      exp_cnt = 0;
      n_checks++;
      if ({pipe_px, hit, pass, score_bcd} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_release: outputs %b expected 0", {pipe_px, hit, pass, score_bcd});
      end
      check_positions("reset_pos");
      probe(320, 39, 1'b1, "gap0_top_edge");
      probe(320, 40, 1'b0, "gap0_open");
      probe(480, 71, 1'b1, "gap1_top_edge");
      probe(480, 72, 1'b0, "gap1_open");
      probe(480, 135, 1'b0, "gap1_last_open");
      probe(480, 136, 1'b1, "gap1_bottom");
      probe(960, 167, 1'b1, "gap4_top_edge");
      probe(960, 168, 1'b0, "gap4_open");
   endtask

   task automatic test_render();
      probe(330, 10, 1'b1, "render_top_body");
      probe(330, 60, 1'b0, "render_gap");
      probe(319, 10, 1'b0, "render_left_of_pipe");
      probe(351, 10, 1'b1, "render_last_col");
      probe(352, 10, 1'b0, "render_past_right");
      probe(330, 103, 1'b0, "render_gap_last_row");
      probe(330, 104, 1'b1, "render_bottom_body");
   endtask

   task automatic test_collision();
      probe_hit(300, 50, 1'b0, "hit_in_gap");
      probe_hit(300, 30, 1'b1, "hit_top_body");
      probe_hit(250, 30, 1'b0, "hit_cols_apart");
      probe_hit(300, 83, 1'b0, "hit_bottom_clear");
      probe_hit(300, 84, 1'b1, "hit_bottom_touch");
      probe_hit(299, 30, 1'b0, "hit_one_short");
   endtask

   task automatic test_scroll_wrap();
      bit col [0:420];
      int g;
      bit ok;
      fish_x = 10'd0; fish_y = 10'd0; run = 1'b1;
      run_ticks(320);
      probe(0, 0, 1'b1, "scroll_p0_at_0");
      probe(160, 0, 1'b1, "scroll_p1_at_160");
      probe(159, 0, 1'b0, "scroll_left_of_p1");
      probe(640, 0, 1'b1, "scroll_p4_at_640");
      check_positions("scroll_pos");
      run_ticks(1);
      probe(799, 0, 1'b1, "wrap_p0_at_799");
      probe(798, 0, 1'b0, "wrap_left_of_p0");
      for (int y = 0; y <= 420; y++) begin
         pixel_x = 10'd799;
         pixel_y = 10'(y);
         @(posedge clk); #1;
         col[y] = pipe_px;
      end
      g = -1;
      for (int y = 0; y <= 420; y++) if (g < 0 && col[y] == 1'b0) g = y;
      n_checks++;
      if (g < 40 || g > 295) begin
         n_fail++;
         $display("FAIL wrap_gap_range: gap_top=%0d expected 40..295", g);
      end else begin
         ok = 1'b1;
         for (int y = g; y < g + 64; y++) if (col[y] !== 1'b0) ok = 1'b0;
         if (col[g + 64] !== 1'b1) ok = 1'b0;
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL wrap_gap_height: opening from %0d is not 64 rows", g);
         end
      end
   endtask

   task automatic test_pass_score();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model_reset();
      exp_cnt = 0;
      fish_x = 10'd100; fish_y = 10'd50; run = 1'b1;
      dut_pass_cnt = 0;
      run_ticks(260);
      n_checks++;
      if (dut_pass_cnt !== 1) begin
         n_fail++;
         $display("FAIL pass_count: %0d pulses expected 1", dut_pass_cnt);
      end
      @(posedge clk); #1;
      n_checks++;
      if (score_bcd !== 8'h01) begin
         n_fail++;
         $display("FAIL score_first: got %h expected 01", score_bcd);
      end
      run_ticks(16100);
      @(posedge clk); #1;
      n_checks++;
      if (score_bcd !== 8'h99) begin
         n_fail++;
         $display("FAIL score_saturate: got %h expected 99 after %0d passes", score_bcd, exp_cnt);
      end
   endtask

   task automatic test_async_reset();
      probe(mx[0], 0, 1'b1, "async_pre_px");
      n_checks++;
      if (score_bcd !== 8'h99) begin
         n_fail++;
         $display("FAIL async_pre_score: got %h expected 99", score_bcd);
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({pipe_px, hit, pass, score_bcd} !== 11'd0) begin
         n_fail++;
         $display("FAIL async_reset: outputs %b expected 0", {pipe_px, hit, pass, score_bcd});
      end
      pixel_x = 10'd0; pixel_y = 10'd0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      model_reset();
      exp_cnt = 0;
      probe(320, 0, 1'b1, "async_release_pos");
   endtask

   task automatic test_freeze_clear();
      bit exp;
      run = 1'b1;
      run_ticks(37);
      run = 1'b0;
      run_ticks(50);
      check_positions("freeze_pos");
      run = 1'b1; tick = 1'b1; clear = 1'b1;
      sb_q.push_back(1'b0);
      @(posedge clk); #1;
      tick = 1'b0; clear = 1'b0;
      model_reset();
      exp_cnt = 0;
      exp = sb_q.pop_front();
      n_checks++;
      if (pass !== exp) begin
         n_fail++;
         $display("FAIL clear_pass: got %0b expected %0b", pass, exp);
      end
      n_checks++;
      if (score_bcd !== 8'h00) begin
         n_fail++;
         $display("FAIL clear_score: got %h expected 00", score_bcd);
      end
      check_positions("clear_pos");
   endtask

   initial begin
      test_reset();
      test_render();
      test_collision();
      test_scroll_wrap();
      test_pass_score();
      test_async_reset();
      test_freeze_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_field_gen.md
# pipe_field_gen

Obstacle generator for the flappy-fish game. Sits directly upstream of the VGA colour stage and the game-state FSM. Owns the scrolling pipe columns and their pseudo-random gap heights, and answers three questions for them:
- per-pixel "is this pixel a pipe" for the green channel;
- "does the fish box overlap a pipe" for the Die transition;
- "fish cleared a pipe" as a pass pulse plus a BCD score for the SSD.

## Interface
Parameters:
- NUM_PIPES, 5, number of pipe columns in rotation
- PIPE_W, 32, pipe width in pixels
- SPACING, 160, left-edge to left-edge distance between consecutive pipes
- START_X, 320, reset x of pipe 0; pipe i resets to START_X + i*SPACING
- GAP_H, 64, vertical opening height
- GAP_MIN, 40, minimum gap_top
- SPEED, 1, pixels moved per tick
- FISH_SIZE, 20, fish box is FISH_SIZE+1 pixels square

Ports:
- clk  in  1  pixel-domain clock (DIV_CLK[1] domain)
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-clk pulse per physics step
- run  in  1  high while the game FSM is in Game
- clear  in  1  synchronous restart to the reset configuration
- pixel_x  in  10  current scan X
- pixel_y  in  10  current scan Y
- fish_x  in  10  fish box left edge
- fish_y  in  10  fish box top edge
- pipe_px  out  1  registered: pixel at (pixel_x, pixel_y) is pipe
- hit  out  1  registered: fish box overlaps any pipe body
- pass  out  1  one-clk pulse: a pipe's right edge crossed fish_x
- score_bcd  out  8  two BCD digits, {tens, ones}

## Operation
- State per pipe i: x[i] (10 b), gap_top[i] (9 b). Pipe body is columns [x, x+PIPE_W). It covers rows y < gap_top and rows y ≥ gap_top+GAP_H.
- Reset (async) and clear (sync): x[i] = START_X + i*SPACING, i.e. 320, 480, 640, 800, 960. gap_top[i] = GAP_MIN + 32*i. score_bcd = 0, pass = 0, pipe_px = 0, hit = 0. lfsr = 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk (not gated by tick), so gaps depend on player timing. clear does not stop it advancing after the clear cycle.
- Step, when tick && run && !clear, for each pipe:
  - If x[i] ≥ SPEED: x[i] ← x[i] − SPEED.
  - Else (wrap): x[i] ← x[i] + NUM_PIPES*SPACING − SPEED (0 → 799) and gap_top[i] ← GAP_MIN + lfsr[7:0] (range 40..295, so the bottom edge is ≤ 359).
- Wrap arithmetic is carried in 11 bits. The left-edge vanish at x=0 is abrupt (accepted).
- tick while run=0 is ignored; positions hold. This is how Die and Win freeze the field.
- pass: on a step, for a non-wrapping pipe, pass = 1 when old x+PIPE_W > fish_x and new x+PIPE_W ≤ fish_x. At most one pass per tick, guaranteed by SPACING > PIPE_W + SPEED.
- score: on pass, increment BCD. Ones 9 → 0 carries into tens. Saturates at 8'h99. clear has priority over tick and pass.
- pipe_px: OR over all pipes of the body test at (pixel_x, pixel_y).
- hit: OR over pipes of box overlap. Fish box is [fish_x, fish_x+FISH_SIZE] × [fish_y, fish_y+FISH_SIZE]. It overlaps a pipe when the column ranges intersect and (fish_y < gap_top or fish_y+FISH_SIZE ≥ gap_top+GAP_H).
- hit is level, not sticky; the game FSM latches Die.

## Timing
- pipe_px: 1 clk latency from pixel_x/pixel_y. The colour stage must align the other channels by the same one cycle.
- Step update: x/gap_top take new values the clk after tick is sampled.
- pass: asserts in that same cycle for exactly 1 clk. score_bcd updates the following clk.
- hit: reflects registered state and fish inputs sampled the previous clk.
- reset_n low mid-frame: all outputs go to 0 immediately, without waiting for clk. Release takes effect on the next clk edge.
- clear and tick in the same cycle: clear wins; no motion, no pass.

## Test plan
- Reset: hold reset_n=0, then release. Required: x = {320,480,640,800,960}, gap_top = {40,72,104,136,168}, score_bcd = 00, all outputs 0.
- Scroll and wrap: run=1, 320 ticks. Required: pipe 0 x = 0 and the others 160/320/480/640. On the 321st tick pipe 0 x = 799 and its gap_top is in 40..295.
- Render: after reset, pixel (330, 10) → pipe_px = 1 one clk later. (330, 60) → 0, because it is in the gap (40..103). (319, 10) → 0.
- Collision: fish at (300, 50) → hit = 0. fish at (300, 30) → hit = 1 (top overlaps rows <40 while the columns overlap). fish at (250, 30) → hit = 0.
- Pass and score: fish_x = 100 and run ticks until pipe 0's right edge crosses 100. Required: exactly one pass pulse, score 01. Force 99 passes → score_bcd = 8'h99, and further passes hold it there.
- Freeze and clear: drop run mid-scroll and keep ticking → positions unchanged. Pulse clear in the same cycle as a tick → reset configuration, no pass.
